// File: rtl/booth_seq_6.sv
// Sequences one shared radix-4 Booth step (booth_6) over 6 digits, MSB-first, to form a signed 12x12->24 product.
// All outputs are registered; with a 1-cycle booth_6 the product appears 13 cycles after start is sampled.
module booth_seq_6 #(
    parameter int WAIT_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] mult_a,
    input  logic [11:0] mult_b,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [23:0] product,
    output logic [2:0]  bs_mult_1,
    output logic [11:0] bs_mult_2,
    output logic [23:0] bs_mult_pre,
    output logic        bs_en,
    input  logic        bs_rdy,
    input  logic [23:0] bs_mult_next
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state, state_nx;
    logic [11:0] a_q, a_nx, b_q, b_nx;
    logic [23:0] acc_q, acc_nx;
    logic [2:0]  idx_q, idx_nx;
    logic [CW-1:0] wcnt_q, wcnt_nx;

    logic        busy_nx, done_nx, err_nx, en_nx;
    logic [23:0] product_nx, pre_nx;
    logic [2:0]  m1_nx;
    logic [11:0] m2_nx;

    // Triplet {B[2i+1], B[2i], B[2i-1]} with B[-1] = 0.
    function automatic logic [2:0] triplet(input logic [11:0] b, input logic [2:0] i);
        logic [12:0] ext;
        ext = {b, 1'b0};
        ext = ext >> {i, 1'b0};
        return ext[2:0];
    endfunction

    always_comb begin
        state_nx   = state;
        a_nx       = a_q;
        b_nx       = b_q;
        acc_nx     = acc_q;
        idx_nx     = idx_q;
        wcnt_nx    = wcnt_q;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        en_nx      = 1'b0;
        product_nx = product;
        pre_nx     = bs_mult_pre;
        m1_nx      = bs_mult_1;
        m2_nx      = bs_mult_2;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mult_a == 12'h800) begin
                        err_nx = 1'b1;
                    end else begin
                        a_nx     = mult_a;
                        b_nx     = mult_b;
                        acc_nx   = '0;
                        idx_nx   = 3'd5;
                        state_nx = ISSUE;
                        en_nx    = 1'b1;
                        m2_nx    = mult_a;
                        pre_nx   = '0;
                        m1_nx    = triplet(mult_b, 3'd5);
                    end
                end
            end
            ISSUE: begin
                state_nx = WAIT;
                wcnt_nx  = '0;
            end
            WAIT: begin
                if (bs_rdy) begin
                    acc_nx = bs_mult_next;
                    if (idx_q == 3'd0) begin
                        state_nx   = DONE;
                        done_nx    = 1'b1;
                        product_nx = bs_mult_next;
                    end else begin
                        // Next issue is registered at the same edge acc updates, so use the incoming value.
                        idx_nx   = idx_q - 3'd1;
                        state_nx = ISSUE;
                        en_nx    = 1'b1;
                        m2_nx    = a_q;
                        pre_nx   = {bs_mult_next[21:0], 2'b00};
                        m1_nx    = triplet(b_q, idx_q - 3'd1);
                    end
                end else if (wcnt_q == CW'(WAIT_MAX - 1)) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    wcnt_nx = wcnt_q + 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            wcnt_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            product     <= '0;
            bs_mult_1   <= '0;
            bs_mult_2   <= '0;
            bs_mult_pre <= '0;
            bs_en       <= 1'b0;
        end else begin
            state       <= state_nx;
            a_q         <= a_nx;
            b_q         <= b_nx;
            acc_q       <= acc_nx;
            idx_q       <= idx_nx;
            wcnt_q      <= wcnt_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            err         <= err_nx;
            product     <= product_nx;
            bs_mult_1   <= m1_nx;
            bs_mult_2   <= m2_nx;
            bs_mult_pre <= pre_nx;
            bs_en       <= en_nx;
        end
    end

endmodule

// File: tb/tb_booth_seq_6.sv
// Bench for booth_seq_6 with a behavioural booth_6 peer that answers in one cycle (or never, when dead).
module tb_booth_seq_6;

    localparam int WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] mult_a, mult_b;
    logic        busy, done, err;
    logic [23:0] product;
    logic [2:0]  bs_mult_1;
    logic [11:0] bs_mult_2;
    logic [23:0] bs_mult_pre;
    logic        bs_en;
    logic        bs_rdy;
    logic [23:0] bs_mult_next;
    bit          stub_dead = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    booth_seq_6 #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mult_a(mult_a), .mult_b(mult_b),
        .busy(busy), .done(done), .err(err), .product(product),
        .bs_mult_1(bs_mult_1), .bs_mult_2(bs_mult_2), .bs_mult_pre(bs_mult_pre),
        .bs_en(bs_en), .bs_rdy(bs_rdy), .bs_mult_next(bs_mult_next)
    );

    function automatic logic [23:0] booth_term(input logic [2:0] t, input logic [11:0] m);
        int mi;
        int r;
        mi = int'($signed(m));
        case (t)
            3'd1, 3'd2: r = mi;
            3'd3:       r = 2 * mi;
            3'd4:       r = -2 * mi;
            3'd5, 3'd6: r = -mi;
            default:    r = 0;
        endcase
        return r[23:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bs_rdy       <= 1'b0;
            bs_mult_next <= '0;
        end else begin
            bs_rdy <= bs_en && !stub_dead;
            if (bs_en) bs_mult_next <= bs_mult_pre + booth_term(bs_mult_1, bs_mult_2);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_mul(input logic signed [11:0] a, input logic signed [11:0] b);
        int ai, bi, p;
        ai = a;
        bi = b;
        p  = ai * bi;
        return p[23:0];
    endfunction

    // One multiply; optionally checks the 13-cycle latency and pokes start while busy.
    task automatic do_mul(input logic [11:0] a, input logic [11:0] b, input bit chk_lat, input bit poke);
        int cyc;
        @(negedge clk);
        mult_a = a;
        mult_b = b;
        start  = 1'b1;
        exp_q.push_back(ref_mul(a, b));
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        if (chk_lat) check("busy_c1", busy, 1);
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (poke && (cyc == 4 || cyc == 8)) begin
                start  = 1'b1;
                mult_a = 12'd11;
                mult_b = 12'd13;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_seen", done, 1);
        if (chk_lat) begin
            check("latency", cyc, 13);
            check("busy_c13", busy, 1);
        end
        if (exp_q.size() > 0) check("product", product, exp_q.pop_front());
        check("no_err", err, 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_off", busy, 0);
    endtask

    initial begin
        logic [23:0] saved;
        int cyc;
        rst_n  = 1'b0;
        start  = 1'b0;
        mult_a = '0;
        mult_b = '0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_product", product, 0);
        check("rst_bs_en", bs_en, 0);
        check("rst_bs_pre", bs_mult_pre, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // T1 with latency, T2 extremes, T3 signs and zero
        do_mul(12'd3, 12'd5, 1'b1, 1'b0);
        check("t1_val", product, 24'h00000F);
        do_mul(12'd2047, 12'd2047, 1'b0, 1'b0);
        check("t2a_val", product, 24'h3FF001);
        do_mul(12'h801, 12'h800, 1'b0, 1'b0);
        check("t2b_val", product, 24'h3FF800);
        do_mul(12'd7, 12'hFFF, 1'b0, 1'b0);
        check("t3a_val", product, 24'hFFFFF9);
        do_mul(12'd0, 12'hB2E, 1'b0, 1'b0);
        check("t3b_val", product, 24'h000000);
        for (int i = 0; i < 8; i++) begin
            int ra;
            logic [11:0] b;
            ra = int'($urandom_range(4094)) - 2047;
            b  = 12'($urandom);
            do_mul(ra[11:0], b, 1'b0, 1'b0);
        end

        // T4: illegal multiplicand
        saved = product;
        @(negedge clk);
        mult_a = 12'h800;
        mult_b = 12'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_err", err, 1);
        check("t4_busy", busy, 0);
        check("t4_product", product, saved);
        @(negedge clk);
        check("t4_err_pulse", err, 0);
        check("t4_busy2", busy, 0);

        // T5: booth_6 never responds
        stub_dead = 1'b1;
        saved = product;
        @(negedge clk);
        mult_a = 12'd3;
        mult_b = 12'd5;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!err && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_err", err, 1);
        check("t5_cycle", cyc, 2 + WAIT_MAX);
        check("t5_busy", busy, 0);
        check("t5_product", product, saved);
        check("t5_done", done, 0);
        stub_dead = 1'b0;
        @(negedge clk);
        check("t5_err_pulse", err, 0);

        // T6: reset during third issue, then a clean multiply with start pokes while busy
        @(negedge clk);
        mult_a = 12'd100;
        mult_b = 12'd100;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_issue3", bs_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_en", bs_en, 0);
        check("t6_product", product, 0);
        check("t6_pre", bs_mult_pre, 0);
        check("t6_m1", bs_mult_1, 0);
        check("t6_m2", bs_mult_2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_mul(12'hFFB, 12'd9, 1'b1, 1'b1);
        check("t6_val", product, 24'hFFFFD3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
